// File: rtl/door_pkg.sv
// Shared types and constants for the automatic door sequencer.
// The state encoding is visible on state_o, so the enum values are fixed.
package door_pkg;

    typedef enum logic [1:0] {
        CLOSED  = 2'b00,
        OPENING = 2'b01,
        OPEN    = 2'b10,
        CLOSING = 2'b11
    } door_state_e;

    localparam int DEF_TRAVEL_CYC = 8;
    localparam int DEF_HOLD_CYC   = 16;
    localparam int DEF_DEB_CYC    = 3;
    localparam int DEF_MAX_REV    = 3;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/door_debounce.sv
// Single-sensor debouncer: the clean output follows raw only after raw has
// disagreed with it for DEB_CYC consecutive cycles.
module door_debounce
    import door_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int CW = cnt_w(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (raw != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/door_seq_ctrl.sv
// Automatic door sequencer: debounced presence, timed travel and open-hold,
// close reversal on presence with an obstruction flag after repeated reversals.
module door_seq_ctrl
    import door_pkg::*;
#(
    parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int MAX_REV    = DEF_MAX_REV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_in,
    input  logic       sensor_out,
    input  logic       lock,
    output logic       motor_en,
    output logic       motor_dir,
    output logic       door_open,
    output logic       timeout,
    output logic       obstruct,
    output logic [1:0] state_o
);

    localparam int PW = cnt_w(TRAVEL_CYC);
    localparam int HW = cnt_w(2 * HOLD_CYC);
    localparam int RW = cnt_w(MAX_REV);

    localparam logic [PW-1:0] POS_FULL      = PW'(TRAVEL_CYC);
    localparam logic [PW-1:0] POS_LAST      = PW'(TRAVEL_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST     = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST_OBS = HW'(2 * HOLD_CYC - 1);
    localparam logic [RW-1:0] REV_SAT       = RW'(MAX_REV);

    door_state_e   state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rev_q, rev_d;
    logic          timeout_q, timeout_d;
    logic          deb_in, deb_out, presence;
    logic [HW-1:0] hold_last;

    door_debounce #(.DEB_CYC(DEB_CYC)) u_deb_in (
        .clk   (clk),
        .rst   (rst),
        .raw   (sensor_in),
        .clean (deb_in)
    );

    door_debounce #(.DEB_CYC(DEB_CYC)) u_deb_out (
        .clk   (clk),
        .rst   (rst),
        .raw   (sensor_out),
        .clean (deb_out)
    );

    // The night lock masks only the outside sensor, and acts on the raw lock pin.
    assign presence  = deb_in | (deb_out & ~lock);
    assign obstruct  = (rev_q == REV_SAT);
    assign hold_last = obstruct ? HOLD_LAST_OBS : HOLD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLOSED;
            pos_q     <= '0;
            hold_q    <= '0;
            rev_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            hold_q    <= hold_d;
            rev_q     <= rev_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = '0;
        rev_d     = rev_q;
        timeout_d = 1'b0;

        case (state_q)
            CLOSED: begin
                pos_d = '0;
                if (presence) begin
                    state_d = OPENING;
                end
            end

            OPENING: begin
                if (pos_q < POS_FULL) begin
                    pos_d = pos_q + 1'b1;
                end
                if (pos_q >= POS_LAST) begin
                    state_d = OPEN;
                end
            end

            OPEN: begin
                if (presence) begin
                    hold_d = '0;
                end else if (hold_q == hold_last) begin
                    state_d   = CLOSING;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            CLOSING: begin
                // Presence beats the final close step: reverse from where we are.
                if (presence) begin
                    state_d = OPENING;
                    if (rev_q != REV_SAT) begin
                        rev_d = rev_q + 1'b1;
                    end
                end else if (pos_q <= PW'(1)) begin
                    pos_d   = '0;
                    state_d = CLOSED;
                    rev_d   = '0;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end

            default: begin
                state_d = CLOSED;
                pos_d   = '0;
            end
        endcase
    end

    assign motor_en  = (state_q == OPENING) || (state_q == CLOSING);
    assign motor_dir = (state_q == OPENING);
    assign door_open = (state_q == OPEN);
    assign timeout   = timeout_q;
    assign state_o   = state_q;

endmodule
